// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single memory port.
// Round-robin on simultaneous requests, one-cycle RELEASE gap between grants.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_req, d_req;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                // On a tie, I wins only if D held the previous grant
                if (i_req && (!d_req || last_grant_q)) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                    mem_addr_d   = i_mem_addr;
                    mem_wdata_d  = i_mem_wdata;
                    mem_write_d  = i_mem_write;
                    mem_read_d   = i_mem_read & ~i_mem_write;
                end else if (d_req) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                    mem_addr_d   = d_mem_addr;
                    mem_wdata_d  = d_mem_wdata;
                    mem_write_d  = d_mem_write;
                    mem_read_d   = d_mem_read & ~d_mem_write;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_d     = RELEASE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        i_mem_rdata = '0;
        d_mem_rdata = '0;
        if (state_q == GRANT_I) begin
            i_mem_ready = mem_ready;
            i_mem_rdata = mem_rdata;
        end
        if (state_q == GRANT_D) begin
            d_mem_ready = mem_ready;
            d_mem_rdata = mem_rdata;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, memory block-address width.
REQ-002 Parameter DATA_W, default 128, memory line width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 proc_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_mem_read, i_mem_write  input  1 each  I-cache request strobes, held until i_mem_ready.
REQ-006 i_mem_addr  input  ADDR_W  I-cache block address; i_mem_wdata  input  DATA_W  I-cache write line.
REQ-007 i_mem_rdata  output  DATA_W  read line to I-cache; i_mem_ready  output  1  I-side completion pulse.
REQ-008 d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata  inputs  1/1/ADDR_W/DATA_W  D-cache request, same rules as I-side.
REQ-009 d_mem_rdata  output  DATA_W; d_mem_ready  output  1  D-side equivalents.
REQ-010 mem_read, mem_write  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  shared memory request.
REQ-011 mem_rdata  input  DATA_W; mem_ready  input  1  shared memory response.

Function
REQ-012 FSM states IDLE, GRANT_I, GRANT_D, RELEASE; one-bit register last_grant (0=I, 1=D).
REQ-013 Client request = its read OR write.
REQ-014 IDLE: only I requesting -> GRANT_I; only D -> GRANT_D; both -> grant side != last_grant (round robin); none -> stay.
REQ-015 On the IDLE->GRANT_x edge, latch client addr, wdata, read, write into mem_addr/mem_wdata/mem_read/mem_write registers; last_grant <= x.
REQ-016 If a client asserts read and write together, latch mem_write=1, mem_read=0.
REQ-017 In GRANT_x, mem_* outputs stay constant; client inputs are not resampled.
REQ-018 x_mem_ready = mem_ready AND state==GRANT_x (combinational); other side's ready stays 0.
REQ-019 x_mem_rdata = mem_rdata while state==GRANT_x, else 0.
REQ-020 GRANT_x with mem_ready -> RELEASE, clearing mem_read/mem_write (mem_addr, mem_wdata cleared to 0); without mem_ready -> stay indefinitely.
REQ-021 RELEASE lasts exactly one cycle, -> IDLE; no grant issued in RELEASE, so the finished client can drop its request.
REQ-022 Minimum issue latency: request seen in IDLE at edge N -> mem_read/mem_write high after edge N+1.
REQ-023 Back-to-back: grant-to-grant spacing >= 3 cycles (GRANT, RELEASE, IDLE).
REQ-024 Request arriving during GRANT/RELEASE of the other side is held by the client and served via REQ-014.
REQ-025 Starvation-free: with both sides continuously requesting, grants alternate I, D, I, D.

Reset
REQ-026 proc_reset_n=0 immediately forces state=IDLE, last_grant=1, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, independent of clk.
REQ-027 Reset mid-transaction abandons the transaction; i_mem_ready=d_mem_ready=0 while in reset; no ready pulse follows deassertion.
REQ-028 First simultaneous request after reset is granted to I.

Verification
REQ-029 Reset, then i_mem_read=1, i_mem_addr=28'h0000123 -> next cycle mem_read=1, mem_addr=28'h0000123; memory mem_ready after 3 cycles with mem_rdata=128'hA5.. -> i_mem_ready 1-cycle pulse, i_mem_rdata=128'hA5.., d_mem_ready=0.
REQ-030 I and D request in same cycle after reset -> I served first; D granted 3 cycles after I's mem_ready; then both continuously requesting -> grant order I,D,I,D.
REQ-031 d_mem_write=1, d_mem_addr=28'h0000040, d_mem_wdata=128'h1234.. -> mem_write=1, mem_read=0, mem_wdata=128'h1234..; d_mem_read=d_mem_write=1 -> mem_write=1, mem_read=0.
REQ-032 D write-back then D read-allocate (d-cache miss with dirty victim) while I idle -> two sequential D grants, RELEASE cycle between, correct addr each.
REQ-033 proc_reset_n=0 asserted in GRANT_D before mem_ready -> outputs zero asynchronously (same cycle), state IDLE, no d_mem_ready after release.
REQ-034 mem_ready held low 50 cycles in GRANT_I -> mem_read, mem_addr stable all 50 cycles, I_ready/D_ready stay 0, D request not granted.
